dir_request_agent: RTL and testbench
====================================

# dir_request_agent

- Initiator for the directory lookup/update port.
- Accepts coherence requests from the two L1 request channels and issues a directory lookup.
- Computes the next directory state, presence vector and Tip vector, then issues the matching directory update.
- Returns a grant plus a probe mask to the requester.
- Sits between the L1 request arbiter and `directory`, and is the only master of the directory port.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 255: watchdog limit per directory transaction. Used only with `DIR_AGENT_TIMEOUT_EN`.

Ports:
- `clk` in 1: the single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: high only in IDLE.
- `req_src` in 1: requesting L1 (0 or 1).
- `req_op` in 2: 0 = ACQUIRE_SHARED, 1 = ACQUIRE_UNIQUE, 2 = RELEASE, 3 = reserved.
- `req_addr` in 64: line address.
- `rsp_valid` out 1: response held until `rsp_ready`.
- `rsp_ready` in 1: response accepted.
- `rsp_src` out 1: copy of `req_src`.
- `rsp_grant` out 2: 0 = none, 1 = Branch, 2 = Tip.
- `rsp_probe_mask` out 2: L1s that must be probed.
- `rsp_error` out 1: reserved op or timeout.
- `lookup_req` out 1
- `lookup_addr` out 64
- `lookup_valid` in 1
- `lookup_state` in 3
- `lookup_presence` in 2
- `lookup_tip_state` in 2
- `update_req` out 1
- `update_addr` out 64
- `update_state` out 3
- `update_presence` out 2
- `update_tip_state` out 2
- `update_done` in 1

## Operation
FSM states: IDLE, LK_ISSUE, LK_WAIT, UPD_ISSUE, UPD_WAIT, RESP.
- **IDLE:** on `req_valid & req_ready`, latch src, op and addr.
  - op 3 -> RESP with `rsp_error` = 1, grant 0, probe mask 0, no directory access.
  - Otherwise -> LK_ISSUE.
- **LK_ISSUE:** `lookup_req` = 1 for exactly this cycle, `lookup_addr` = latched addr. Next state LK_WAIT.
- **LK_WAIT:** wait for `lookup_valid`, then compute the new entry (s = one-hot src, P = `lookup_presence`, T = `lookup_tip_state`). Next state UPD_ISSUE.
  - ACQUIRE_SHARED: probe = T & ~s; presence = P | s; tip = 00; state = DIR_STATE_SHARED; grant = Branch.
  - ACQUIRE_UNIQUE: probe = P & ~s; presence = s; tip = s; state = DIR_STATE_EXCLUSIVE; grant = Tip.
  - RELEASE: probe = 00; presence = P & ~s; tip = 00; state = DIR_STATE_INVALID if the new presence is 00, else DIR_STATE_SHARED; grant = none.
- **UPD_ISSUE:** `update_req` = 1 for exactly this cycle, `update_addr` = latched addr. Next state UPD_WAIT.
- **UPD_WAIT:** wait for `update_done`, then -> RESP.
- **RESP:** `rsp_valid` = 1 and all `rsp_*` fields stable until `rsp_ready`, then -> IDLE.

Rules:
- `update_state`, `update_presence` and `update_tip_state` are driven from UPD_ISSUE through UPD_WAIT and stay stable until `update_done`, because the directory samples them one cycle after `update_req`.
- `lookup_req` and `update_req` are never high in the same cycle.
- Each is a single-cycle pulse per transaction; the directory re-triggers on a level that is still high.
- DIR_STATE_* encodings come from `tidc_params.v`.

## Timing
- Reset value of every output is 0, except `req_ready` = 1 once in IDLE. The FSM resets to IDLE.
- Nominal path, counted from the acceptance cycle as cycle 0:

| Cycle | Event |
|---|---|
| 1 | `lookup_req` |
| 3 | `lookup_valid` |
| 4 | `update_req` |
| 6 | `update_done` |
| 7 | `rsp_valid` |

- Throughput: one request per 8 cycles when `rsp_ready` is held high.
- Reserved op: `rsp_valid` in cycle 1.
- `lookup_valid` or `update_done` arriving outside its wait state is ignored.
- Reset asserted mid-transaction: abort immediately, all outputs return to 0, no response is produced, and the pending update is dropped.
- A `req_valid` that stays high while the block is busy is not accepted until the cycle after RESP completes.

## Configuration
- `DIR_AGENT_TIMEOUT_EN` defined:
  - A counter clears on entry to LK_WAIT or UPD_WAIT and increments every cycle spent there.
  - When it reaches `TIMEOUT_CYCLES` the FSM moves to RESP with `rsp_error` = 1, grant 0 and probe mask 0.
  - A timed-out lookup issues no update.
- Not defined: no counter exists, `rsp_error` is set only for op 3, and the FSM waits indefinitely.

## Test plan
- **Empty entry:** src 0, ACQUIRE_SHARED, addr 0x1000 -> `lookup_req` at cycle 1; update to SHARED, presence 01, tip 00; `rsp_grant` = 1, probe mask 00, `rsp_valid` at cycle 7.
- **Upgrade over sharer:** entry SHARED, presence 01; src 1 ACQUIRE_UNIQUE -> update EXCLUSIVE, presence 10, tip 10; `rsp_grant` = 2, `rsp_probe_mask` = 01.
- **Release:** entry EXCLUSIVE, presence 10, tip 10; src 1 RELEASE -> update INVALID, presence 00, tip 00; `rsp_grant` = 0.
- **Reserved op and backpressure:** op 3 -> `rsp_error` = 1 at cycle 1 with `lookup_req` never asserted. With `rsp_ready` low for 5 cycles, `rsp_valid` and all fields stay stable and `req_ready` stays 0.
- **Reset mid-transaction:** `rst_n` pulsed low during UPD_WAIT -> all outputs 0 and FSM in IDLE. A subsequent request completes normally.
- **Timeout (`DIR_AGENT_TIMEOUT_EN`, `TIMEOUT_CYCLES` = 10):** `lookup_valid` suppressed -> `rsp_error` = 1, with `rsp_valid` 11 cycles after LK_WAIT entry and no `update_req`.

Source files
------------

// File: rtl/dir_request_agent.sv
// dir_request_agent: sole master of the directory port. Turns L1 coherence requests into one lookup,
// one update and a grant/probe response. Optional wait watchdog: define DIR_AGENT_TIMEOUT_EN.
//
// state     | meaning
// IDLE      | ready to accept a request
// LK_ISSUE  | single-cycle lookup_req pulse
// LK_WAIT   | waiting for lookup_valid
// UPD_ISSUE | single-cycle update_req pulse, update payload valid
// UPD_WAIT  | payload held until update_done
// RESP      | response held until rsp_ready
module dir_request_agent #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_src,
    input  logic [1:0]  req_op,
    input  logic [63:0] req_addr,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_src,
    output logic [1:0]  rsp_grant,
    output logic [1:0]  rsp_probe_mask,
    output logic        rsp_error,
    output logic        lookup_req,
    output logic [63:0] lookup_addr,
    input  logic        lookup_valid,
    input  logic [2:0]  lookup_state,
    input  logic [1:0]  lookup_presence,
    input  logic [1:0]  lookup_tip_state,
    output logic        update_req,
    output logic [63:0] update_addr,
    output logic [2:0]  update_state,
    output logic [1:0]  update_presence,
    output logic [1:0]  update_tip_state,
    input  logic        update_done
);

    // Directory state encodings, kept identical to tidc_params.v
    localparam logic [2:0] DIR_STATE_INVALID   = 3'd0;
    localparam logic [2:0] DIR_STATE_SHARED    = 3'd1;
    localparam logic [2:0] DIR_STATE_EXCLUSIVE = 3'd2;

    localparam logic [1:0] OP_ACQ_SHARED = 2'd0;
    localparam logic [1:0] OP_ACQ_UNIQUE = 2'd1;
    localparam logic [1:0] OP_RELEASE    = 2'd2;
    localparam logic [1:0] OP_RESERVED   = 2'd3;

    localparam logic [1:0] GRANT_NONE   = 2'd0;
    localparam logic [1:0] GRANT_BRANCH = 2'd1;
    localparam logic [1:0] GRANT_TIP    = 2'd2;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LK_ISSUE  = 3'd1,
        LK_WAIT   = 3'd2,
        UPD_ISSUE = 3'd3,
        UPD_WAIT  = 3'd4,
        RESP      = 3'd5
    } state_t;

    state_t      state, state_nx;
    logic        src_r;
    logic [1:0]  op_r;
    logic [63:0] addr_r;
    logic [1:0]  grant_r, probe_r;
    logic        error_r;
    logic [2:0]  upd_state_r;
    logic [1:0]  upd_pres_r, upd_tip_r;
    logic [1:0]  src_oh;
    logic [2:0]  calc_state;
    logic [1:0]  calc_pres, calc_tip, calc_grant, calc_probe;
    logic        timeout_hit;
    logic        timeout_fire;
    logic        upd_phase;
    logic        unused_lookup_state;

    // The next entry depends only on who asks and who holds it, not on the old state code.
    assign unused_lookup_state = ^lookup_state;
    assign src_oh = src_r ? 2'b10 : 2'b01;

`ifdef DIR_AGENT_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] wait_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if (state == LK_ISSUE || state == UPD_ISSUE) begin
            wait_cnt <= '0;
        end else if (state == LK_WAIT || state == UPD_WAIT) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
        end
    end

    assign timeout_hit = (wait_cnt == CNT_W'(TIMEOUT_CYCLES));
`else
    logic [31:0] unused_timeout_cycles;
    assign unused_timeout_cycles = 32'(TIMEOUT_CYCLES);
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        req_ready    = 1'b0;
        lookup_req   = 1'b0;
        update_req   = 1'b0;
        rsp_valid    = 1'b0;
        timeout_fire = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_nx = (req_op == OP_RESERVED) ? RESP : LK_ISSUE;
                end
            end
            LK_ISSUE: begin
                lookup_req = 1'b1;
                state_nx   = LK_WAIT;
            end
            LK_WAIT: begin
                if (lookup_valid) begin
                    state_nx = UPD_ISSUE;
                end else if (timeout_hit) begin
                    state_nx     = RESP;
                    timeout_fire = 1'b1;
                end
            end
            UPD_ISSUE: begin
                update_req = 1'b1;
                state_nx   = UPD_WAIT;
            end
            UPD_WAIT: begin
                if (update_done) begin
                    state_nx = RESP;
                end else if (timeout_hit) begin
                    state_nx     = RESP;
                    timeout_fire = 1'b1;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        calc_state = DIR_STATE_INVALID;
        calc_pres  = 2'b00;
        calc_tip   = 2'b00;
        calc_grant = GRANT_NONE;
        calc_probe = 2'b00;
        case (op_r)
            OP_ACQ_SHARED: begin
                calc_probe = lookup_tip_state & ~src_oh;
                calc_pres  = lookup_presence | src_oh;
                calc_state = DIR_STATE_SHARED;
                calc_grant = GRANT_BRANCH;
            end
            OP_ACQ_UNIQUE: begin
                calc_probe = lookup_presence & ~src_oh;
                calc_pres  = src_oh;
                calc_tip   = src_oh;
                calc_state = DIR_STATE_EXCLUSIVE;
                calc_grant = GRANT_TIP;
            end
            OP_RELEASE: begin
                calc_pres  = lookup_presence & ~src_oh;
                calc_state = (calc_pres == 2'b00) ? DIR_STATE_INVALID : DIR_STATE_SHARED;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src_r       <= 1'b0;
            op_r        <= 2'd0;
            addr_r      <= '0;
            grant_r     <= 2'd0;
            probe_r     <= 2'd0;
            error_r     <= 1'b0;
            upd_state_r <= 3'd0;
            upd_pres_r  <= 2'd0;
            upd_tip_r   <= 2'd0;
        end else if (state == IDLE && req_valid) begin
            src_r       <= req_src;
            op_r        <= req_op;
            addr_r      <= req_addr;
            grant_r     <= GRANT_NONE;
            probe_r     <= 2'd0;
            error_r     <= (req_op == OP_RESERVED);
            upd_state_r <= 3'd0;
            upd_pres_r  <= 2'd0;
            upd_tip_r   <= 2'd0;
        end else if (state == LK_WAIT && lookup_valid) begin
            grant_r     <= calc_grant;
            probe_r     <= calc_probe;
            upd_state_r <= calc_state;
            upd_pres_r  <= calc_pres;
            upd_tip_r   <= calc_tip;
        end else if (timeout_fire) begin
            grant_r <= GRANT_NONE;
            probe_r <= 2'd0;
            error_r <= 1'b1;
        end
    end

    // Payload is held through UPD_WAIT since the directory samples it a cycle after update_req.
    assign upd_phase        = (state == UPD_ISSUE) || (state == UPD_WAIT);
    assign lookup_addr      = lookup_req ? addr_r : '0;
    assign update_addr      = upd_phase ? addr_r : '0;
    assign update_state     = upd_phase ? upd_state_r : 3'd0;
    assign update_presence  = upd_phase ? upd_pres_r : 2'd0;
    assign update_tip_state = upd_phase ? upd_tip_r : 2'd0;

    assign rsp_src        = rsp_valid ? src_r : 1'b0;
    assign rsp_grant      = rsp_valid ? grant_r : 2'd0;
    assign rsp_probe_mask = rsp_valid ? probe_r : 2'd0;
    assign rsp_error      = rsp_valid ? error_r : 1'b0;

endmodule

// File: tb/tb_dir_request_agent.sv
// Directed bench for dir_request_agent: the bench plays the directory, keeps a per-address
// entry model, and a negedge compare process checks every output against a cycle timeline.
module tb_dir_request_agent;

    localparam int TO = 10;
    localparam logic [2:0] D_INV = 3'd0;
    localparam logic [2:0] D_SHR = 3'd1;
    localparam logic [2:0] D_EXC = 3'd2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0, req_src = 1'b0;
    logic [1:0]  req_op = 2'd0;
    logic [63:0] req_addr = '0;
    logic        req_ready, rsp_valid, rsp_src, rsp_error;
    logic        rsp_ready = 1'b0;
    logic [1:0]  rsp_grant, rsp_probe_mask;
    logic        lookup_req, update_req;
    logic [63:0] lookup_addr, update_addr;
    logic        lookup_valid = 1'b0, update_done = 1'b0;
    logic [2:0]  lookup_state = 3'd0;
    logic [1:0]  lookup_presence = 2'd0, lookup_tip_state = 2'd0;
    logic [2:0]  update_state;
    logic [1:0]  update_presence, update_tip_state;

    dir_request_agent #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_src(req_src), .req_op(req_op), .req_addr(req_addr),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_src(rsp_src), .rsp_grant(rsp_grant),
        .rsp_probe_mask(rsp_probe_mask), .rsp_error(rsp_error),
        .lookup_req(lookup_req), .lookup_addr(lookup_addr), .lookup_valid(lookup_valid),
        .lookup_state(lookup_state), .lookup_presence(lookup_presence), .lookup_tip_state(lookup_tip_state),
        .update_req(update_req), .update_addr(update_addr), .update_state(update_state),
        .update_presence(update_presence), .update_tip_state(update_tip_state), .update_done(update_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
        end
    endtask

    // Directory contents as the bench believes them
    logic [2:0] m_state [bit [63:0]];
    logic [1:0] m_pres  [bit [63:0]];
    logic [1:0] m_tip   [bit [63:0]];

    // Per-L1 reading of the coherence rules
    function automatic void model_entry(input logic src, input logic [1:0] op,
                                        input logic [1:0] p, input logic [1:0] t,
                                        output logic [2:0] st, output logic [1:0] np,
                                        output logic [1:0] nt, output logic [1:0] gr,
                                        output logic [1:0] pr, output logic er);
        st = D_INV; np = 2'b00; nt = 2'b00; gr = 2'd0; pr = 2'b00; er = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bit me;
            me = (i == int'(src));
            case (op)
                2'd0: begin pr[i] = t[i] && !me; np[i] = p[i] || me; end
                2'd1: begin pr[i] = p[i] && !me; np[i] = me; nt[i] = me; end
                2'd2: np[i] = p[i] && !me;
                default: ;
            endcase
        end
        case (op)
            2'd0: begin st = D_SHR; gr = 2'd1; end
            2'd1: begin st = D_EXC; gr = 2'd2; end
            2'd2: st = (np == 2'b00) ? D_INV : D_SHR;
            default: er = 1'b1;
        endcase
    endfunction

    // Timeline of the transaction in flight
    bit          act_txn = 1'b0;
    bit          e_dir, e_to;
    int          t0, lk_c, upd_c, done_c, rsp_c, end_c;
    logic [63:0] e_addr;
    logic        e_src, e_err;
    logic [2:0]  e_state;
    logic [1:0]  e_pres, e_tip, e_grant, e_probe;

    int          seen_lk_cyc, seen_rsp_cyc, seen_upd_cnt;
    logic [2:0]  seen_upd_state;
    logic [1:0]  seen_upd_pres, seen_upd_tip, seen_grant, seen_probe;
    logic        seen_err;

    always @(negedge clk) begin
        bit busy, lk, uw, rv;
        busy = act_txn && cyc > t0 && cyc <= end_c;
        lk   = act_txn && e_dir && cyc == lk_c;
        uw   = act_txn && e_dir && !e_to && cyc >= upd_c && cyc <= done_c;
        rv   = act_txn && cyc >= rsp_c && cyc <= end_c;
        chk("req_ready", req_ready, !busy);
        chk("lookup_req", lookup_req, lk);
        chk("lookup_addr", lookup_addr, lk ? e_addr : 64'd0);
        chk("update_req", update_req, uw && cyc == upd_c);
        chk("req_excl", lookup_req & update_req, 1'b0);
        chk("update_addr", update_addr, uw ? e_addr : 64'd0);
        chk("update_state", update_state, uw ? e_state : 3'd0);
        chk("update_presence", update_presence, uw ? e_pres : 2'd0);
        chk("update_tip", update_tip_state, uw ? e_tip : 2'd0);
        chk("rsp_valid", rsp_valid, rv);
        chk("rsp_src", rsp_src, rv ? e_src : 1'b0);
        chk("rsp_grant", rsp_grant, rv ? e_grant : 2'd0);
        chk("rsp_probe", rsp_probe_mask, rv ? e_probe : 2'd0);
        chk("rsp_error", rsp_error, rv ? e_err : 1'b0);
        if (act_txn && cyc == t0) begin
            seen_lk_cyc = -1; seen_rsp_cyc = -1; seen_upd_cnt = 0;
        end
        if (lookup_req && seen_lk_cyc < 0) seen_lk_cyc = cyc;
        if (update_req) begin
            seen_upd_cnt++;
            seen_upd_state = update_state; seen_upd_pres = update_presence; seen_upd_tip = update_tip_state;
        end
        if (rsp_valid && seen_rsp_cyc < 0) begin
            seen_rsp_cyc = cyc; seen_grant = rsp_grant; seen_probe = rsp_probe_mask; seen_err = rsp_error;
        end
    end

    task automatic do_txn(input logic src, input logic [1:0] op, input logic [63:0] addr,
                          input int lv_at, input int done_gap, input int hold,
                          input bit keep_valid, input bit spur, input int rst_at, input bit no_lookup);
        logic [2:0] cur_st, n_st;
        logic [1:0] cur_p, cur_t, n_p, n_t, gr, pr;
        logic er;
        bit last;
        cur_st = m_state.exists(addr) ? m_state[addr] : D_INV;
        cur_p  = m_pres.exists(addr) ? m_pres[addr] : 2'b00;
        cur_t  = m_tip.exists(addr) ? m_tip[addr] : 2'b00;
        model_entry(src, op, cur_p, cur_t, n_st, n_p, n_t, gr, pr, er);
        if (no_lookup) begin er = 1'b1; gr = 2'd0; pr = 2'd0; end
        t0 = cyc; e_dir = (op != 2'd3); e_to = no_lookup; e_addr = addr; e_src = src;
        e_state = n_st; e_pres = n_p; e_tip = n_t; e_grant = gr; e_probe = pr; e_err = er;
        lk_c = t0 + 1; upd_c = -100; done_c = -100;
        if (!e_dir) rsp_c = t0 + 1;
        else if (no_lookup) rsp_c = t0 + 2 + TO + 1;
        else begin
            upd_c = t0 + lv_at + 1; done_c = upd_c + done_gap; rsp_c = done_c + 1;
        end
        end_c = rsp_c + hold;
        act_txn = 1'b1;
        req_valid = 1'b1; req_src = src; req_op = op; req_addr = addr;
        for (int c = t0; c <= t0 + 400; c++) begin
            last = (rst_at > 0) ? (c == t0 + rst_at + 1) : (c == end_c);
            lookup_valid = 1'b0; lookup_state = 3'd0; lookup_presence = 2'd0; lookup_tip_state = 2'd0;
            update_done = 1'b0; rsp_ready = 1'b0;
            if (c > t0) begin
                req_valid = keep_valid; req_src = ~src; req_op = op + 2'd1; req_addr = ~addr;
            end
            if (rst_at > 0 && c == t0 + rst_at) begin rst_n = 1'b0; act_txn = 1'b0; end
            if (rst_at > 0 && c == t0 + rst_at + 1) rst_n = 1'b1;
            if (e_dir && !no_lookup && c == t0 + lv_at) begin
                lookup_valid = 1'b1; lookup_state = cur_st; lookup_presence = cur_p; lookup_tip_state = cur_t;
            end
            if (spur && (c == t0 + 1 || c == upd_c + 1)) begin
                lookup_valid = 1'b1; lookup_state = 3'd7; lookup_presence = 2'b11; lookup_tip_state = 2'b11;
            end
            if (spur && c == t0 + 2) update_done = 1'b1;
            if (e_dir && !no_lookup && c == done_c) update_done = 1'b1;
            if (spur && c < rsp_c) rsp_ready = 1'b1;
            if (c == end_c) rsp_ready = 1'b1;
            @(posedge clk); #1;
            if (last) break;
        end
        if (e_dir && !no_lookup && rst_at == 0) begin
            m_state[addr] = n_st; m_pres[addr] = n_p; m_tip[addr] = n_t;
        end
        req_valid = 1'b0; lookup_valid = 1'b0; update_done = 1'b0; rsp_ready = 1'b0;
        lookup_state = 3'd0; lookup_presence = 2'd0; lookup_tip_state = 2'd0;
        act_txn = 1'b0;
    endtask

    initial begin
        int t_a;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // Empty entry, nominal timing
        do_txn(1'b0, 2'd0, 64'h1000, 3, 2, 0, 1'b0, 1'b0, 0, 1'b0);
        chk("t1_lookup_cycle", 64'(seen_lk_cyc - t0), 64'd1);
        chk("t1_rsp_cycle", 64'(seen_rsp_cyc - t0), 64'd7);
        chk("t1_upd_state", seen_upd_state, 3'd1);
        chk("t1_upd_pres", {seen_upd_pres, seen_upd_tip}, 4'b0100);
        chk("t1_grant_probe", {seen_grant, seen_probe}, 4'b0100);

        // Upgrade over sharer, req_valid held high while busy
        do_txn(1'b1, 2'd1, 64'h1000, 3, 2, 0, 1'b1, 1'b0, 0, 1'b0);
        t_a = t0;
        chk("t2_upd", {seen_upd_state, seen_upd_pres, seen_upd_tip}, {3'd2, 2'b10, 2'b10});
        chk("t2_grant_probe", {seen_grant, seen_probe}, 4'b1001);

        // Release of the exclusive copy, accepted back-to-back
        do_txn(1'b1, 2'd2, 64'h1000, 3, 2, 0, 1'b0, 1'b0, 0, 1'b0);
        chk("t3_throughput", 64'(t0 - t_a), 64'd8);
        chk("t3_upd", {seen_upd_state, seen_upd_pres, seen_upd_tip}, {3'd0, 2'b00, 2'b00});
        chk("t3_grant", seen_grant, 2'd0);

        // Reserved op with five cycles of backpressure
        do_txn(1'b0, 2'd3, 64'h5555, 3, 2, 5, 1'b0, 1'b0, 0, 1'b0);
        chk("t4_rsp_cycle", 64'(seen_rsp_cyc - t0), 64'd1);
        chk("t4_error", seen_err, 1'b1);
        chk("t4_no_lookup", seen_lk_cyc < 0, 1'b1);

        // Tip owner probed by a shared acquire; slow directory and stray handshakes
        do_txn(1'b0, 2'd1, 64'h2000, 3, 2, 0, 1'b0, 1'b0, 0, 1'b0);
        do_txn(1'b1, 2'd0, 64'h2000, 6, 4, 0, 1'b0, 1'b1, 0, 1'b0);
        chk("t6_probe", seen_probe, 2'b01);
        chk("t6_upd", {seen_upd_state, seen_upd_pres, seen_upd_tip}, {3'd1, 2'b11, 2'b00});
        do_txn(1'b1, 2'd2, 64'h2000, 3, 2, 0, 1'b0, 1'b0, 0, 1'b0);
        chk("t7_upd", {seen_upd_state, seen_upd_pres}, {3'd1, 2'b01});

        // Reset in UPD_WAIT drops the update; the follow-up sees an empty entry
        do_txn(1'b0, 2'd1, 64'h3000, 3, 4, 0, 1'b0, 1'b0, 5, 1'b0);
        do_txn(1'b0, 2'd0, 64'h3000, 3, 2, 0, 1'b0, 1'b0, 0, 1'b0);
        chk("t9_after_reset", {seen_upd_pres, seen_probe, seen_grant}, {2'b01, 2'b00, 2'd1});

`ifdef DIR_AGENT_TIMEOUT_EN
        do_txn(1'b1, 2'd0, 64'h4000, 3, 2, 0, 1'b0, 1'b0, 0, 1'b1);
        chk("t10_to_rsp", 64'(seen_rsp_cyc - (t0 + 2)), 64'd11);
        chk("t10_to_err", seen_err, 1'b1);
        chk("t10_no_update", 64'(seen_upd_cnt), 64'd0);
        do_txn(1'b1, 2'd0, 64'h4000, 3, 2, 0, 1'b0, 1'b0, 0, 1'b0);
        chk("t11_upd_pres", seen_upd_pres, 2'b10);
`endif

        repeat (2) @(posedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1, "watchdog");
    end

endmodule
